pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/mips_pkg.sv | 25 ++
 rtl/pc_increment.sv | 13 +
 rtl/pc_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-side PC logic.
//   ADDR_W / INSTR_BYTES : address width and instruction size in bytes
//   pc_state_e           : sequencer state encoding (also visible on the debug port)
//   DEF_RESET_PC / DEF_EXC_VECTOR : default reset and exception addresses
//   word_align()         : clears the byte-offset bits of a fetch address
package mips_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEF_EXC_VECTOR = 32'h0000_0180;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STALL    = 2'd2,
    ST_REDIRECT = 2'd3
  } pc_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_increment.sv
// Sequential-address adder for the fetch stage.
//   addr      : current fetch address
//   addr_next : addr + INSTR_BYTES, wrapping modulo 2^ADDR_W (carry out dropped)
module pc_increment
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_next
);

  assign addr_next = addr + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, fetch-control FSM and redirect counter.
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   stall                 : hold the IF stage
//   jump / jump_target    : ID-stage jump
//   branch_taken / branch_target : EX-stage taken branch
//   exception             : exception from a later stage, vectors to EXC_VECTOR
//   pc, pc_plus4          : current fetch address and its sequential successor
//   fetch_valid           : instruction at pc is valid (low in BOOT and REDIRECT)
//   flush                 : squash younger pipeline contents (high in REDIRECT)
//   redirect_count        : saturating count of redirect edges
//   state                 : debug view of the FSM state (pc_state_e encoding)
//
// Handshake: there is no valid/ready pair here; the hazard unit owns stall and the
// sequencer obeys it every cycle unless a redirect (exception/branch/jump) overrides.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exception,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic [15:0] redirect_count,
  output logic [1:0]  state
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] count_q;
  logic        redirect;

  pc_increment u_inc (
    .addr      (pc_q),
    .addr_next (pc_plus4)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect && (count_q != 16'hFFFF)) begin
        count_q <= count_q + 16'h0001;
      end
    end
  end

  // Priority: exception > branch_taken > jump > stall > sequential.
  // Leaving BOOT or REDIRECT holds pc: those cycles are fetch bubbles, so the
  // address they present (reset PC or redirect target) is fetched validly next.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redirect = 1'b0;
    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end else if (exception) begin
      pc_d     = word_align(EXC_VECTOR);
      state_d  = ST_REDIRECT;
      redirect = 1'b1;
    end else if (branch_taken) begin
      pc_d     = word_align(branch_target);
      state_d  = ST_REDIRECT;
      redirect = 1'b1;
    end else if (jump) begin
      pc_d     = word_align(jump_target);
      state_d  = ST_REDIRECT;
      redirect = 1'b1;
    end else if (stall) begin
      state_d = ST_STALL;
    end else if (state_q == ST_REDIRECT) begin
      state_d = ST_RUN;
    end else begin
      pc_d    = pc_plus4;
      state_d = ST_RUN;
    end
  end

  assign pc             = pc_q;
  assign fetch_valid    = (state_q == ST_RUN) || (state_q == ST_STALL);
  assign flush          = (state_q == ST_REDIRECT);
  assign redirect_count = count_q;
  assign state          = state_q;

endmodule
